// File: rtl/mps_adc_guard_pkg.sv
// Shared constants for the MPS ADC capture/protection block: channel map,
// default geometry and the derived channel-index width helper.
package mps_adc_pkg;

    // Channel map of the MPS ADC front end
    localparam int unsigned CH_C        = 0;
    localparam int unsigned CH_V        = 1;
    localparam int unsigned CH_DC_V     = 2;
    localparam int unsigned CH_PH_R     = 3;
    localparam int unsigned CH_PH_S     = 4;
    localparam int unsigned CH_PH_T     = 5;
    localparam int unsigned CH_DC_C     = 6;
    localparam int unsigned CH_IGBT_T   = 7;
    localparam int unsigned CH_IND_I_T  = 8;
    localparam int unsigned CH_IND_O_T  = 9;

    // Default geometry
    localparam int unsigned DEF_N_CH    = 10;
    localparam int unsigned DEF_DW      = 32;
    localparam int unsigned DEF_DEB_CNT = 3;

    // Channel-index width, never narrower than one bit
    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mps_adc_guard_if.sv
// Bus bundle between the ADC/register side (master) and the guard (slave).
interface mps_adc_guard_if #(
    parameter int unsigned N_CH = mps_adc_pkg::DEF_N_CH,
    parameter int unsigned DW   = mps_adc_pkg::DEF_DW,
    parameter int unsigned CH_W = mps_adc_pkg::ch_idx_w(N_CH)
);
    logic [N_CH*DW-1:0] i_tdata;
    logic [N_CH-1:0]    i_tvalid;
    logic [N_CH*DW-1:0] i_max_lim;
    logic [N_CH*DW-1:0] i_min_lim;
    logic [N_CH-1:0]    i_intl_mask;
    logic               i_intl_clr;
    logic               i_stat_clr;
    logic [N_CH*DW-1:0] o_data;
    logic [N_CH*DW-1:0] o_peak_max;
    logic [N_CH*DW-1:0] o_peak_min;
    logic [N_CH-1:0]    o_intl;
    logic               o_intl_any;
    logic [CH_W-1:0]    o_first_fault;
    logic               o_first_valid;

    modport master (
        output i_tdata, i_tvalid, i_max_lim, i_min_lim, i_intl_mask,
               i_intl_clr, i_stat_clr,
        input  o_data, o_peak_max, o_peak_min, o_intl, o_intl_any,
               o_first_fault, o_first_valid
    );

    modport slave (
        input  i_tdata, i_tvalid, i_max_lim, i_min_lim, i_intl_mask,
               i_intl_clr, i_stat_clr,
        output o_data, o_peak_max, o_peak_min, o_intl, o_intl_any,
               o_first_fault, o_first_valid
    );

endinterface

// File: rtl/mps_adc_guard_ch.sv
// One ADC channel: sample hold, signed range test, debounce counter,
// sticky interlock flag and peak max/min tracking. o_trip pulses on the
// edge that completes the debounce run.
module mps_adc_guard_ch #(
    parameter int unsigned DW      = 32,
    parameter int unsigned DEB_CNT = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [DW-1:0] i_tdata,
    input  logic          i_tvalid,
    input  logic [DW-1:0] i_max_lim,
    input  logic [DW-1:0] i_min_lim,
    input  logic          i_mask,
    input  logic          i_intl_clr,
    input  logic          i_stat_clr,
    output logic [DW-1:0] o_data,
    output logic [DW-1:0] o_peak_max,
    output logic [DW-1:0] o_peak_min,
    output logic          o_intl,
    output logic          o_trip
);

    localparam int unsigned    CW       = $clog2(DEB_CNT + 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(DEB_CNT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CNT - 1);

    logic signed [DW-1:0] x, hi, lo;
    logic                 out_rng, bad, trip;

    logic [CW-1:0]        cnt_q, cnt_d, cnt_base;
    logic                 intl_q, intl_d;
    logic [DW-1:0]        data_q, data_d;
    logic signed [DW-1:0] pmax_q, pmax_d, pmin_q, pmin_d;
    logic                 pv_q, pv_d;

    assign x  = i_tdata;
    assign hi = i_max_lim;
    assign lo = i_min_lim;

    // min_lim > max_lim makes every sample fail one of the two tests
    assign out_rng = (x > hi) || (x < lo);
    assign bad     = i_tvalid && out_rng && !i_mask;
    assign trip    = bad && (cnt_q == CNT_LAST);

    // Next-state for debounce, interlock, hold and peaks
    always_comb begin
        cnt_base = i_intl_clr ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if (i_tvalid) begin
            if (bad)
                cnt_d = (cnt_base == CNT_MAX) ? CNT_MAX : cnt_base + CW'(1);
            else
                cnt_d = '0;
        end
        // a completing bad beat beats a simultaneous clear
        if (trip)
            cnt_d = CNT_MAX;

        intl_d = trip || (intl_q && !i_intl_clr);
        data_d = i_tvalid ? i_tdata : data_q;
        pv_d   = i_tvalid || (pv_q && !i_stat_clr);

        pmax_d = pmax_q;
        pmin_d = pmin_q;
        if (i_tvalid) begin
            if (!pv_q || i_stat_clr) begin
                pmax_d = x;
                pmin_d = x;
            end else begin
                if (x > pmax_q) pmax_d = x;
                if (x < pmin_q) pmin_d = x;
            end
        end
    end

    // Channel state registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q  <= '0;
            intl_q <= 1'b0;
            data_q <= '0;
            pmax_q <= '0;
            pmin_q <= '0;
            pv_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            intl_q <= intl_d;
            data_q <= data_d;
            pmax_q <= pmax_d;
            pmin_q <= pmin_d;
            pv_q   <= pv_d;
        end
    end

    assign o_data     = data_q;
    assign o_peak_max = pmax_q;
    assign o_peak_min = pmin_q;
    assign o_intl     = intl_q;
    assign o_trip     = trip;

endmodule

// File: rtl/mps_adc_guard.sv
// N-channel ADC capture and protection top: per-channel guards, lowest-index
// first-fault latch, registered interlock summary and bus flattening.
module mps_adc_guard
    import mps_adc_pkg::*;
#(
    parameter int unsigned N_CH    = DEF_N_CH,
    parameter int unsigned DW      = DEF_DW,
    parameter int unsigned DEB_CNT = DEF_DEB_CNT
) (
    input  logic           i_clk,
    input  logic           i_rst,
    mps_adc_guard_if.slave bus
);

    localparam int unsigned CH_W = ch_idx_w(N_CH);

    logic [DW-1:0]   data_w [N_CH];
    logic [DW-1:0]   pmax_w [N_CH];
    logic [DW-1:0]   pmin_w [N_CH];
    logic [N_CH-1:0] intl_w;
    logic [N_CH-1:0] trip_w;

    logic [CH_W-1:0] trip_idx;
    logic            trip_any;
    logic [CH_W-1:0] ff_q, ff_d;
    logic            fv_q, fv_d;
    logic            any_q, any_d;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        mps_adc_guard_ch #(
            .DW      (DW),
            .DEB_CNT (DEB_CNT)
        ) u_ch (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_tdata    (bus.i_tdata[k*DW +: DW]),
            .i_tvalid   (bus.i_tvalid[k]),
            .i_max_lim  (bus.i_max_lim[k*DW +: DW]),
            .i_min_lim  (bus.i_min_lim[k*DW +: DW]),
            .i_mask     (bus.i_intl_mask[k]),
            .i_intl_clr (bus.i_intl_clr),
            .i_stat_clr (bus.i_stat_clr),
            .o_data     (data_w[k]),
            .o_peak_max (pmax_w[k]),
            .o_peak_min (pmin_w[k]),
            .o_intl     (intl_w[k]),
            .o_trip     (trip_w[k])
        );
    end

    // Lowest-index trip this edge, and first-fault / summary next-state
    always_comb begin
        trip_idx = '0;
        trip_any = 1'b0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (trip_w[k] && !trip_any) begin
                trip_idx = CH_W'(k);
                trip_any = 1'b1;
            end
        end

        ff_d = ff_q;
        fv_d = fv_q;
        // a trip on the clear edge reloads the latch instead of leaving it empty
        if (trip_any && (!fv_q || bus.i_intl_clr)) begin
            ff_d = trip_idx;
            fv_d = 1'b1;
        end else if (bus.i_intl_clr) begin
            ff_d = '0;
            fv_d = 1'b0;
        end

        any_d = |intl_w;
    end

    // First-fault and summary registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ff_q  <= '0;
            fv_q  <= 1'b0;
            any_q <= 1'b0;
        end else begin
            ff_q  <= ff_d;
            fv_q  <= fv_d;
            any_q <= any_d;
        end
    end

    // Flatten per-channel results onto the bus
    always_comb begin
        bus.o_data     = '0;
        bus.o_peak_max = '0;
        bus.o_peak_min = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            bus.o_data[k*DW +: DW]     = data_w[k];
            bus.o_peak_max[k*DW +: DW] = pmax_w[k];
            bus.o_peak_min[k*DW +: DW] = pmin_w[k];
        end
    end

    assign bus.o_intl        = intl_w;
    assign bus.o_intl_any    = any_q;
    assign bus.o_first_fault = ff_q;
    assign bus.o_first_valid = fv_q;

endmodule

// File: tb/tb_mps_adc_guard.sv
// Scoreboard bench for mps_adc_guard: stimulus queues expected values tagged
// with the edge after which they must hold; a negedge monitor compares them.
module tb_mps_adc_guard;

    localparam int unsigned N   = 10;
    localparam int unsigned W   = 32;
    localparam int unsigned DEB = 3;

    localparam int K_DATA = 0;
    localparam int K_PMAX = 1;
    localparam int K_PMIN = 2;
    localparam int K_INTL = 3;
    localparam int K_ANY  = 4;
    localparam int K_FF   = 5;
    localparam int K_FV   = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mps_adc_guard_if #(.N_CH(N), .DW(W)) bus ();

    mps_adc_guard #(.N_CH(N), .DW(W), .DEB_CNT(DEB)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        int          kind;
        int          ch;
        logic [31:0] exp;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          ecount   = 0;
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] act;

    always @(posedge clk) ecount++;

    function automatic logic [31:0] actual(input int kind, input int ch);
        case (kind)
            K_DATA:  return bus.o_data[ch*W +: W];
            K_PMAX:  return bus.o_peak_max[ch*W +: W];
            K_PMIN:  return bus.o_peak_min[ch*W +: W];
            K_INTL:  return 32'(bus.o_intl);
            K_ANY:   return 32'(bus.o_intl_any);
            K_FF:    return 32'(bus.o_first_fault);
            default: return 32'(bus.o_first_valid);
        endcase
    endfunction

    // Monitor: compare every entry whose edge has been reached
    always @(negedge clk) begin
        for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
            if (sb[i].due <= ecount) begin
                checks++;
                act = actual(sb[i].kind, sb[i].ch);
                if (act !== sb[i].exp) begin
                    failures++;
                    $display("FAIL %s ch%0d: got %0h expected %0h",
                             sb[i].name, sb[i].ch, act, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    task automatic chk(input string n, input int kind, input int ch,
                       input logic [31:0] v, input int dly);
        exp_t e;
        e.name = n; e.kind = kind; e.ch = ch; e.exp = v; e.due = ecount + dly;
        sb.push_back(e);
    endtask

    task automatic smp(input int ch, input logic [31:0] v);
        bus.i_tdata[ch*W +: W] = v;
        bus.i_tvalid[ch]       = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.i_tvalid   = '0;
        bus.i_intl_clr = 1'b0;
        bus.i_stat_clr = 1'b0;
    endtask

    int s2 [6] = '{1001, 1001, 500, 1001, 1001, 1001};
    int s5 [4] = '{-5, 40, -300, 12};

    initial begin
        bus.i_tdata     = '0;
        bus.i_tvalid    = '0;
        bus.i_intl_mask = '0;
        bus.i_intl_clr  = 1'b0;
        bus.i_stat_clr  = 1'b0;
        for (int k = 0; k < N; k++) begin
            bus.i_max_lim[k*W +: W] = 32'(1000);
            bus.i_min_lim[k*W +: W] = 32'(-1000);
        end
        chk("por_intl", K_INTL, 0, 0, 0);
        chk("por_fv",   K_FV,   0, 0, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // 1: reset mid-stream with ch0 counter at 2 and peaks loaded
        smp(0, 32'(2000)); tick();
        smp(0, 32'(2000)); tick();
        chk("pre_rst_pmax", K_PMAX, 0, 32'(2000), 0);
        tick();
        rst = 1'b1;
        chk("rst_data",  K_DATA, 0, 0, 0);
        chk("rst_pmax",  K_PMAX, 0, 0, 0);
        chk("rst_pmin",  K_PMIN, 0, 0, 0);
        chk("rst_intl",  K_INTL, 0, 0, 0);
        chk("rst_any",   K_ANY,  0, 0, 0);
        chk("rst_ff",    K_FF,   0, 0, 0);
        chk("rst_fv",    K_FV,   0, 0, 0);
        tick();
        rst = 1'b0;
        tick();
        smp(0, 32'(2000)); tick();
        chk("t1_intl",  K_INTL, 0, 0, 0);
        chk("t1_data",  K_DATA, 0, 32'(2000), 0);
        chk("t1_pmin",  K_PMIN, 0, 32'(2000), 0);
        smp(0, 32'(0)); tick();

        // 2: debounce restarts after an in-range beat
        for (int i = 0; i < 6; i++) begin
            smp(1, 32'(s2[i]));
            tick();
            if (i == 1) chk("t2_early", K_INTL, 0, 0, 0);
            if (i == 4) chk("t2_5th",   K_INTL, 0, 0, 0);
        end
        chk("t2_intl", K_INTL, 0, 32'h002, 0);
        chk("t2_ff",   K_FF,   0, 1, 0);
        chk("t2_fv",   K_FV,   0, 1, 0);
        chk("t2_any0", K_ANY,  0, 0, 0);
        chk("t2_any1", K_ANY,  0, 1, 1);
        bus.i_intl_clr = 1'b1; tick();
        chk("clr_intl", K_INTL, 0, 0, 0);
        chk("clr_ff",   K_FF,   0, 0, 0);
        chk("clr_fv",   K_FV,   0, 0, 0);
        chk("clr_any",  K_ANY,  0, 0, 1);

        // 3: simultaneous trips pick the lowest index; later trips ignored
        for (int i = 0; i < 3; i++) begin
            smp(4, 32'(1500)); smp(7, 32'(-1500)); tick();
        end
        chk("t3_intl", K_INTL, 0, 32'h090, 0);
        chk("t3_ff",   K_FF,   0, 4, 0);
        for (int i = 0; i < 3; i++) begin
            smp(2, 32'(5000)); tick();
        end
        chk("t3_intl2", K_INTL, 0, 32'h094, 0);
        chk("t3_ff2",   K_FF,   0, 4, 0);

        // 4: masked channel never trips; trip wins over simultaneous clear
        bus.i_intl_mask[5] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            smp(5, 32'(-2000)); tick();
        end
        chk("t4_mask",  K_INTL, 0, 32'h094, 0);
        chk("t4_data5", K_DATA, 5, 32'(-2000), 0);
        bus.i_intl_clr = 1'b1; tick();
        for (int i = 0; i < 3; i++) begin
            smp(3, 32'(1001)); tick();
        end
        chk("t4_ch3",  K_INTL, 0, 32'h008, 0);
        chk("t4_ff3",  K_FF,   0, 3, 0);
        smp(6, 32'(-1001)); tick();
        smp(6, 32'(-1001)); tick();
        smp(6, 32'(-1001)); bus.i_intl_clr = 1'b1; tick();
        chk("t4_intl", K_INTL, 0, 32'h040, 0);
        chk("t4_ff6",  K_FF,   0, 6, 0);
        chk("t4_fv",   K_FV,   0, 1, 0);

        // 5: peak tracking and stat clear
        for (int i = 0; i < 4; i++) begin
            smp(9, 32'(s5[i])); tick();
        end
        chk("t5_pmax", K_PMAX, 9, 32'(40), 0);
        chk("t5_pmin", K_PMIN, 9, 32'(-300), 0);
        chk("t5_data", K_DATA, 9, 32'(12), 0);
        smp(9, 32'(7)); bus.i_stat_clr = 1'b1; tick();
        chk("t5_clr_max", K_PMAX, 9, 32'(7), 0);
        chk("t5_clr_min", K_PMIN, 9, 32'(7), 0);
        bus.i_stat_clr = 1'b1; tick();
        chk("t5_hold", K_PMAX, 9, 32'(7), 0);
        smp(9, 32'(100)); tick();
        chk("t5_rel_max", K_PMAX, 9, 32'(100), 0);
        chk("t5_rel_min", K_PMIN, 9, 32'(100), 0);

        // 6: limits inclusive, then signed extremes
        for (int i = 0; i < 5; i++) begin
            smp(8, 32'(1000)); smp(0, 32'(-1000)); tick();
        end
        chk("t6_edge", K_INTL, 0, 32'h040, 0);
        for (int i = 0; i < 3; i++) begin
            smp(8, 32'h7FFF_FFFF); smp(0, 32'h8000_0000); tick();
        end
        chk("t6_intl", K_INTL, 0, 32'h141, 0);
        chk("t6_ff",   K_FF,   0, 6, 0);
        chk("t6_any",  K_ANY,  0, 1, 1);
        chk("t6_pmin0", K_PMIN, 0, 32'h8000_0000, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            failures += int'(sb.size());
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
